// File: rtl/bp_update_sched.sv
// bp_update_sched: orders resolved-branch records onto the gshare exe update port
// and sequences full BHT flushes, buffering resolutions that arrive mid-flush.
module bp_update_sched #(
    parameter int         BHT_ENTRIES     = 256,
    parameter int         INSTR_SIZE_BYTE = 4,
    parameter int         FIFO_DEPTH      = 8,
    parameter logic [1:0] INIT_CTR        = 2'b01,
    localparam int        IDX_W           = $clog2(BHT_ENTRIES),
    localparam int        PC_W            = INSTR_SIZE_BYTE * 8,
    localparam int        LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [PC_W-1:0]   res_pc,
    input  logic              res_taken,
    input  logic [PC_W-1:0]   res_offset,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              fetch_hold,
    output logic              upd_nop,
    output logic [PC_W-1:0]   upd_pc,
    output logic              upd_taken,
    output logic [PC_W-1:0]   upd_offset,
    output logic              init_we,
    output logic [IDX_W-1:0]  init_idx,
    output logic [1:0]        init_data,
    output logic              ghr_clr,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BHT_ENTRIES - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, FLUSH} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] offset;
    } rec_t;

    state_t            state_q, state_d;
    rec_t              mem [FIFO_DEPTH];
    rec_t              in_rec, head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              empty, accept, push, pop, bypass, start, last;

    assign empty      = (fifo_level == '0);
    assign res_ready  = !rst && (fifo_level != FULL_LVL);
    assign accept     = res_valid && res_ready;
    assign in_rec     = '{pc: res_pc, taken: res_taken, offset: res_offset};
    assign head       = mem[rd_ptr];
    assign last       = (init_idx == LAST_IDX);
    assign fetch_hold = flush_busy;

    // Next-state and per-edge FIFO/update decisions.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        bypass  = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    push    = accept;
                    start   = 1'b1;
                    state_d = FLUSH;
                end else begin
                    pop    = !empty;
                    push   = accept && !empty;
                    bypass = accept && empty;
                end
            end
            FLUSH: begin
                push = accept;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered update-port and flush-control outputs.
    always_ff @(posedge clk) begin
        init_data <= INIT_CTR;
        if (rst) begin
            state_q    <= IDLE;
            upd_nop    <= 1'b1;
            upd_pc     <= '0;
            upd_taken  <= 1'b0;
            upd_offset <= '0;
            init_we    <= 1'b0;
            init_idx   <= '0;
            ghr_clr    <= 1'b0;
            flush_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            upd_nop    <= !(pop || bypass);
            if (pop) begin
                upd_pc     <= head.pc;
                upd_taken  <= head.taken;
                upd_offset <= head.offset;
            end else if (bypass) begin
                upd_pc     <= in_rec.pc;
                upd_taken  <= in_rec.taken;
                upd_offset <= in_rec.offset;
            end
            ghr_clr    <= start;
            init_we    <= (state_d == FLUSH);
            flush_busy <= (state_d == FLUSH);
            init_idx   <= (state_q == FLUSH && !last) ? init_idx + 1'b1 : '0;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_rec;
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_bp_update_sched;

    logic        clk = 1'b0;
    logic        rst, res_valid, res_ready, res_taken, flush_req;
    logic [31:0] res_pc, res_offset;
    logic        flush_busy, fetch_hold, upd_nop, upd_taken, init_we, ghr_clr;
    logic [31:0] upd_pc, upd_offset;
    logic [7:0]  init_idx;
    logic [1:0]  init_data;
    logic [3:0]  fifo_level;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] off;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    bp_update_sched #(
        .BHT_ENTRIES(256),
        .INSTR_SIZE_BYTE(4),
        .FIFO_DEPTH(8),
        .INIT_CTR(2'b01)
    ) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_taken(res_taken), .res_offset(res_offset),
        .flush_req(flush_req), .flush_busy(flush_busy), .fetch_hold(fetch_hold),
        .upd_nop(upd_nop), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_offset(upd_offset),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
        .ghr_clr(ghr_clr), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: every presented update must match the scoreboard head, in the expected cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && upd_nop === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected actual pc=%0h taken=%0b off=%0h cyc=%0d required=no update",
                         upd_pc, upd_taken, upd_offset, ecnt);
            end else begin
                m_e = sb.pop_front();
                if (upd_pc !== m_e.pc || upd_taken !== m_e.taken || upd_offset !== m_e.off ||
                    (m_e.due >= 0 && ecnt != m_e.due)) begin
                    errors++;
                    $display("FAIL upd_record actual pc=%0h taken=%0b off=%0h cyc=%0d required pc=%0h taken=%0b off=%0h cyc=%0d",
                             upd_pc, upd_taken, upd_offset, ecnt, m_e.pc, m_e.taken, m_e.off, m_e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_rec(input logic [31:0] pc, input logic tk, input logic [31:0] off, input int due);
        exp_t e;
        e.pc = pc; e.taken = tk; e.off = off; e.due = due;
        sb.push_back(e);
    endtask

    logic we_s  [300];
    logic clr_s [300];
    int   idx_s [300];

    initial begin
        int e_edge, t, bad, gap, nclr;

        // 1: reset with valid and flush pending
        rst = 1'b1; res_valid = 1'b1; flush_req = 1'b1;
        res_pc = 32'h0; res_taken = 1'b0; res_offset = 32'h0;
        step();
        chk("rst_ready0_a", res_ready, 0);
        step();
        chk("rst_ready0_b", res_ready, 0);
        rst = 1'b0; res_valid = 1'b0; flush_req = 1'b0;
        chk("rst_upd_nop", upd_nop, 1);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_upd_taken", upd_taken, 0);
        chk("rst_upd_offset", upd_offset, 0);
        chk("rst_init_we", init_we, 0);
        chk("rst_init_idx", init_idx, 0);
        chk("rst_init_data", init_data, 1);
        chk("rst_ghr_clr", ghr_clr, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_fetch_hold", fetch_hold, 0);
        chk("rst_fifo_level", fifo_level, 0);
        step();
        chk("rst_ready1", res_ready, 1);
        chk("rst_idle_nop", upd_nop, 1);

        // 2: single bypass record
        res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_offset = 32'd5;
        chk("single_ready", res_ready, 1);
        expect_rec(32'h40, 1'b1, 32'd5, ecnt + 1);
        step();
        res_valid = 1'b0;
        chk("single_level", fifo_level, 0);
        step();
        chk("single_nop_after", upd_nop, 1);

        // 3: 20 back-to-back bypass records
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            res_valid = 1'b1; res_pc = 32'(4 * k); res_taken = k[0]; res_offset = 32'(k);
            if (res_ready !== 1'b1) bad++;
            expect_rec(32'(4 * k), k[0], 32'(k), ecnt + 1);
            step();
            if (fifo_level !== 4'd0) bad++;
        end
        res_valid = 1'b0;
        chk("b2b_ready_level", bad, 0);
        step();
        step();
        chk("b2b_drained", sb.size(), 0);

        // 4: flush pulse with resolutions arriving during the walk
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        e_edge = ecnt;
        chk("fl_ghr_clr", ghr_clr, 1);
        chk("fl_init_we", init_we, 1);
        chk("fl_init_idx0", init_idx, 0);
        chk("fl_busy", flush_busy, 1);
        chk("fl_hold", fetch_hold, 1);
        chk("fl_nop", upd_nop, 1);
        fork
            begin
                int b = 0;
                for (int k = 1; k < 256; k++) begin
                    step();
                    if (!(init_we === 1'b1 && init_idx === 8'(k) && ghr_clr === 1'b0 &&
                          flush_busy === 1'b1 && fetch_hold === 1'b1 && upd_nop === 1'b1)) b++;
                end
                chk("fl_walk_bad_cycles", b, 0);
                step();
                chk("fl_end_busy", flush_busy, 0);
                chk("fl_end_hold", fetch_hold, 0);
                chk("fl_end_we", init_we, 0);
                chk("fl_end_idx", init_idx, 0);
                chk("fl_end_nop", upd_nop, 1);
            end
            begin
                int due_tab [10];
                for (int i = 0; i < 8; i++) due_tab[i] = e_edge + 257 + i;
                due_tab[8] = e_edge + 265;
                due_tab[9] = e_edge + 266;
                for (int i = 0; i < 10; i++) begin
                    int w = 0;
                    res_valid = 1'b1; res_pc = 32'h1000 + 32'(8 * i);
                    res_taken = i[0]; res_offset = 32'h100 + 32'(i);
                    if (i == 8) begin
                        chk("fl_full_level", fifo_level, 8);
                        chk("fl_full_ready", res_ready, 0);
                    end
                    while (res_ready !== 1'b1 && w < 400) begin
                        step();
                        w++;
                    end
                    if (res_ready !== 1'b1) begin
                        chk("fl_accept_timeout", res_ready, 1);
                    end else begin
                        expect_rec(32'h1000 + 32'(8 * i), i[0], 32'h100 + 32'(i), due_tab[i]);
                        step();
                    end
                end
                res_valid = 1'b0;
            end
        join
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            step();
            t++;
        end
        chk("fl_replay_drained", sb.size(), 0);
        chk("fl_replay_level", fifo_level, 0);

        // 5: flush_req held for 300 cycles
        flush_req = 1'b1;
        for (int j = 0; j < 300; j++) begin
            step();
            we_s[j] = init_we; clr_s[j] = ghr_clr; idx_s[j] = int'(init_idx);
        end
        flush_req = 1'b0;
        gap = 300; bad = 0; nclr = 0;
        for (int j = 299; j >= 0; j--) if (we_s[j] !== 1'b1) gap = j;
        for (int j = 0; j < 256; j++) if (idx_s[j] != j) bad++;
        for (int j = 0; j < 300; j++) if (clr_s[j] === 1'b1) nclr++;
        chk("hold_write_count", gap, 256);
        chk("hold_idx_seq_bad", bad, 0);
        chk("hold_restart_we", we_s[257], 1);
        chk("hold_restart_idx", idx_s[257], 0);
        chk("hold_restart_clr", clr_s[257], 1);
        chk("hold_clr_pulses", nclr, 2);
        t = 0;
        while (flush_busy !== 1'b0 && t < 300) begin
            step();
            t++;
        end
        chk("hold_second_done", flush_busy, 0);
        step();

        // 6: reset in the middle of a flush with buffered records
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = 32'hdead0000 + 32'(i); res_taken = 1'b1; res_offset = 32'(i);
            step();
        end
        res_valid = 1'b0;
        chk("abort_level_pre", fifo_level, 3);
        t = 0;
        while (init_idx !== 8'd100 && t < 300) begin
            step();
            t++;
        end
        chk("abort_reach_idx100", init_idx, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_we", init_we, 0);
        chk("abort_busy", flush_busy, 0);
        chk("abort_hold", fetch_hold, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_nop", upd_nop, 1);
        chk("abort_idx", init_idx, 0);
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (init_we !== 1'b0 || upd_nop !== 1'b1 || flush_busy !== 1'b0) bad++;
        end
        chk("abort_quiet_after", bad, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
